// File: rtl/apb_dmem_if.sv
// APB bus bundle between the core's dmem master and the data-memory responder.
interface apb_dmem_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_dmem_responder.sv
// APB completer for the dmem segment: word RAM, byte strobes,
// programmable wait states and error response.
module apb_dmem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       rst,
  apb_dmem_if.slave  bus
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    strb_q, strb_d;
  logic          pready_q, pready_d;
  logic          pslverr_q, pslverr_d;
  logic [31:0]   prdata_q, prdata_d;
  logic          mem_we;

  logic [31:0]   mem [MEM_WORDS];

  logic [31:0]   off;
  logic          below;
  logic          oob;
  logic          misal;
  logic          strb_ok;
  logic          req_err;

  assign off   = bus.paddr - BASE_ADDR;
  assign below = bus.paddr < BASE_ADDR;
  assign oob   = {2'b00, off[31:2]} >= MEM_WORDS;
  assign misal = |bus.paddr[1:0];

  // Only naturally aligned byte/half/word lanes are legal; 0000 is a no-op.
  always_comb begin
    strb_ok = 1'b0;
    case (bus.pstrb)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111:
        strb_ok = 1'b1;
      default:
        strb_ok = 1'b0;
    endcase
  end

  assign req_err = misal | below | oob
                 | (bus.pwrite & ~strb_ok);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    err_d     = err_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          state_d = ACCESS;
          wr_d    = bus.pwrite;
          err_d   = req_err;
          idx_d   = off[AW+1:2];
          wdata_d = bus.pwdata;
          strb_d  = bus.pstrb;
          cnt_d   = 4'(WAIT_STATES);
          if (!bus.pwrite)
            prdata_d = req_err ? 32'h0
                               : mem[off[AW+1:2]];
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d   = DONE;
          pready_d  = 1'b1;
          pslverr_d = err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        mem_we  = wr_q & ~err_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'h0;
      strb_q    <= 4'h0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i])
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_dmem_responder.sv
// Directed bench: WAIT_STATES=0 instance (u=0) and WAIT_STATES=3 instance (u=1).
module tb_apb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        u = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] pwdata = 32'h0;
  logic [3:0]  pstrb = 4'h0;
  logic        pready_m;
  logic        pslverr_m;
  logic [31:0] prdata_m;
  int          cyc = 0;
  int          nchk = 0;
  int          nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_dmem_if bus0();
  apb_dmem_if bus1();

  assign bus0.psel    = psel & ~u;
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;
  assign bus1.psel    = psel & u;
  assign bus1.penable = penable;
  assign bus1.pwrite  = pwrite;
  assign bus1.paddr   = paddr;
  assign bus1.pwdata  = pwdata;
  assign bus1.pstrb   = pstrb;

  assign pready_m  = u ? bus1.pready  : bus0.pready;
  assign pslverr_m = u ? bus1.pslverr : bus0.pslverr;
  assign prdata_m  = u ? bus1.prdata  : bus0.prdata;

  apb_dmem_responder #(
    .MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  apb_dmem_responder #(
    .MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after pready.
  task automatic xfer(input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output bit err, output logic [31:0] rd,
                      output int lat, output int cat);
    bit got;
    got = 1'b0; err = 1'b0; rd = 32'h0; lat = 0; cat = 0;
    psel = 1'b1; penable = 1'b0;
    pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int n = 1; n <= 30 && !got; n++) begin
      @(negedge clk);
      if (pready_m) begin
        got = 1'b1;
        lat = n;
        cat = cyc;
        err = pslverr_m;
        rd = prdata_m;
      end
    end
    if (!got) begin
      nchk++;
      nerr++;
      $display("FAIL timeout: pready never seen for addr %h", a);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    bit          eerr;
    logic [31:0] erd;
  } vec_t;

  vec_t        v[20];
  bit          e;
  logic [31:0] r;
  int          l, c0, c1, c2, hits;

  initial begin
    v[0]  = '{1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 32'h0};
    v[1]  = '{0, 32'h10,   32'h0,        4'h0, 0, 32'hDEADBEEF};
    v[2]  = '{1, 32'h10,   32'h000000AA, 4'h1, 0, 32'h0};
    v[3]  = '{1, 32'h10,   32'h55660000, 4'hC, 0, 32'h0};
    v[4]  = '{0, 32'h10,   32'h0,        4'h0, 0, 32'h5566BEAA};
    v[5]  = '{0, 32'h13,   32'h0,        4'h0, 1, 32'h0};
    v[6]  = '{1, 32'h1000, 32'h12345678, 4'hF, 1, 32'h0};
    v[7]  = '{1, 32'h10,   32'hFFFFFFFF, 4'h5, 1, 32'h0};
    v[8]  = '{0, 32'h10,   32'h0,        4'hF, 0, 32'h5566BEAA};
    v[9]  = '{1, 32'h14,   32'hCAFEF00D, 4'hF, 0, 32'h0};
    v[10] = '{1, 32'h14,   32'h12345678, 4'h0, 0, 32'h0};
    v[11] = '{0, 32'h14,   32'h0,        4'h0, 0, 32'hCAFEF00D};
    v[12] = '{1, 32'h14,   32'h0000ABCD, 4'h3, 0, 32'h0};
    v[13] = '{0, 32'h14,   32'h0,        4'h0, 0, 32'hCAFEABCD};
    v[14] = '{1, 32'h0,    32'h11111111, 4'hF, 0, 32'h0};
    v[15] = '{1, 32'h4,    32'h22222222, 4'hF, 0, 32'h0};
    v[16] = '{1, 32'h8,    32'h33333333, 4'hF, 0, 32'h0};
    v[17] = '{0, 32'h1000, 32'h0,        4'h0, 1, 32'h0};
    v[18] = '{1, 32'hFFC,  32'h77777777, 4'hF, 0, 32'h0};
    v[19] = '{0, 32'hFFC,  32'h0,        4'h0, 0, 32'h77777777};

    repeat (3) @(posedge clk);
    #1;
    chk("rst pready0",  {31'h0, bus0.pready},  32'h0);
    chk("rst pslverr0", {31'h0, bus0.pslverr}, 32'h0);
    chk("rst prdata0",  bus0.prdata,           32'h0);
    chk("rst pready1",  {31'h0, bus1.pready},  32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Protocol violation: penable without setup must be ignored.
    penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("penable idle", {31'h0, bus0.pready}, 32'h0);
    @(posedge clk); #1;
    penable = 1'b0;

    u = 1'b0;
    for (int i = 0; i < 20; i++) begin
      xfer(v[i].w, v[i].a, v[i].d, v[i].s, e, r, l, c0);
      chk($sformatf("vec%0d lat", i), l, 32'd2);
      chk($sformatf("vec%0d err", i), {31'h0, e},
          {31'h0, v[i].eerr});
      if (!v[i].w)
        chk($sformatf("vec%0d rdata", i), r, v[i].erd);
    end
    @(negedge clk);
    chk("pulse ws0", {31'h0, pready_m}, 32'h0);
    @(posedge clk); #1;

    // Back-to-back reads, setup right after each pready.
    xfer(0, 32'h0, 32'h0, 4'h0, e, r, l, c0);
    chk("b2b rd0", r, 32'h11111111);
    xfer(0, 32'h4, 32'h0, 4'h0, e, r, l, c1);
    chk("b2b rd1", r, 32'h22222222);
    xfer(0, 32'h8, 32'h0, 4'h0, e, r, l, c2);
    chk("b2b rd2", r, 32'h33333333);
    chk("b2b gap1", c1 - c0, 32'd3);
    chk("b2b gap2", c2 - c1, 32'd3);

    // Wait-state instance.
    u = 1'b1;
    xfer(1, 32'h20, 32'hA5A5A5A5, 4'hF, e, r, l, c0);
    chk("ws3 wr lat", l, 32'd5);
    chk("ws3 wr err", {31'h0, e}, 32'h0);
    xfer(0, 32'h20, 32'h0, 4'h0, e, r, l, c0);
    chk("ws3 rd lat", l, 32'd5);
    chk("ws3 rd data", r, 32'hA5A5A5A5);
    @(negedge clk);
    chk("ws3 pulse", {31'h0, pready_m}, 32'h0);
    @(posedge clk); #1;

    // Abort: psel drops mid access phase.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h20; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    hits = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (pready_m) hits++;
    end
    chk("abort pready", hits, 32'd0);
    @(posedge clk); #1;
    xfer(0, 32'h20, 32'h0, 4'h0, e, r, l, c0);
    chk("abort ram", r, 32'hA5A5A5A5);

    // Reset during a pending write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h20; pwdata = 32'h0BADF00D; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst pready",  {31'h0, pready_m},  32'h0);
    chk("rst pslverr", {31'h0, pslverr_m}, 32'h0);
    chk("rst prdata",  prdata_m,           32'h0);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    xfer(0, 32'h20, 32'h0, 4'h0, e, r, l, c0);
    chk("rst discard", r, 32'hA5A5A5A5);
    chk("rst rd lat", l, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/apb_dmem_responder.md
Name: apb_dmem_responder

Overview:
APB completer that serves the data-memory bus driven by the core's load/store path. It holds a word-organised data RAM, decodes APB setup/access phases and applies byte strobes on writes. It returns full 32-bit words on reads, with a configurable number of wait states and error signalling. It sits on the dmem APB segment opposite the core's APB master.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the RAM (power of two)
BASE_ADDR, 32'h0000_0000, byte address of word 0
WAIT_STATES, 0, extra access-phase cycles before pready (0..15)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
psel  input  1  APB select
penable  input  1  APB access phase
pwrite  input  1  1 = write, 0 = read
paddr  input  32  byte address
pwdata  input  32  write data
pstrb  input  4  write byte strobes
pready  output  1  transfer complete
prdata  output  32  read data, valid when pready & !pwrite
pslverr  output  1  error, valid only while pready

Behaviour:
- Reset (async, rst=1): state IDLE, pready=0, pslverr=0, prdata=0, wait counter=0. RAM contents are not reset.
- States:
  - IDLE: no transfer.
  - ACCESS: transfer captured, counting wait states.
  - DONE: pready asserted for exactly one cycle.
- IDLE -> ACCESS on psel & !penable (setup phase). On that edge:
  - capture pwrite, paddr, pwdata, pstrb
  - load counter = WAIT_STATES
  - compute err
  - for reads with err=0, register RAM[word index] into prdata
- ACCESS:
  - if !psel: abort to IDLE, no RAM write, no pready.
  - else if counter==0: go to DONE.
  - else decrement the counter.
- DONE: pready=1, pslverr=err. A write with err=0 commits on this edge: only bytes with pstrb[i]=1 update, with byte i = pwdata[8i+7:8i]. Next state is IDLE.
- Back-to-back: a new setup phase in the cycle after DONE is accepted from IDLE normally.
- Latency: pready is high in access-phase cycle WAIT_STATES+2 counted from the setup cycle (cycle 1).
  - WAIT_STATES=0: setup T0, pready at T2 (access phase lasts 2 cycles).
- pready, pslverr and prdata are registered outputs. pready=0 in all states except DONE, and pslverr=0 whenever pready=0.
- prdata holds its last value between transfers. On error reads prdata=32'h0.
- err is set when any of the following holds:
  - paddr[1:0] != 0
  - (paddr - BASE_ADDR) >> 2 >= MEM_WORDS, or paddr < BASE_ADDR
  - a write with pstrb not one of: 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
- pstrb=4'b0000 on a write: no bytes change, no error.
- pstrb is ignored on reads.
- Word index = (paddr - BASE_ADDR)[log2(MEM_WORDS)+1:2].
- Error writes never modify the RAM.
- penable asserted while in IDLE (protocol violation): ignored, stay IDLE.
- Reset mid-transfer: immediate return to IDLE with outputs at reset values; an in-flight write is discarded.

Test Plan:
- Word write/read, WAIT_STATES=0: write paddr=0x10, pwdata=0xDEADBEEF, pstrb=4'hF, then read 0x10 -> pready high in the 2nd access cycle both times, prdata=0xDEADBEEF, pslverr=0.
- Byte/half strobes: after the above, write 0x10 pwdata=0x000000AA pstrb=4'b0001, then write pwdata=0x55660000 pstrb=4'b1100, then read 0x10 -> prdata=0x5566BEAA.
- Errors: read 0x13 -> pslverr=1, prdata=0. Write 0x1000 (MEM_WORDS=1024) -> pslverr=1. Write 0x10 with pstrb=4'b0101 -> pslverr=1 and a follow-up read 0x10 returns the unchanged 0x5566BEAA.
- Wait states, WAIT_STATES=3: read from setup at T0 -> pready=0 at T1..T4, pready=1 at T5 for exactly one cycle.
- Abort/reset: deassert psel during the access phase of a write to 0x20 -> no pready, RAM[0x20] unchanged. Assert rst during a pending write -> pready=0, pslverr=0, and the write is discarded.
- Back-to-back: three consecutive reads of 0x0, 0x4, 0x8 with setup the cycle after each pready -> three pready pulses, 3 cycles apart, with correct data each.
